// File: rtl/traffic_light_fsm_if.sv
// Lamp-controller port bundle: divider tick and hold in, lamps/state/phase pulse out.
// master = the side that drives tick_in/hold (and ped_req), slave = the controller.
// Ports: tick_in, hold, red, yellow, green, state_o[1:0], phase_done,
//        plus ped_req/ped_walk when TLC_PED_REQ_EN is defined.
interface traffic_light_fsm_if;
   logic       tick_in;
   logic       hold;
   logic       red;
   logic       yellow;
   logic       green;
   logic [1:0] state_o;
   logic       phase_done;
`ifdef TLC_PED_REQ_EN
   logic       ped_req;
   logic       ped_walk;

   modport master (
      output tick_in, hold, ped_req,
      input  red, yellow, green, state_o, phase_done, ped_walk
   );

   modport slave (
      input  tick_in, hold, ped_req,
      output red, yellow, green, state_o, phase_done, ped_walk
   );
`else
   modport master (
      output tick_in, hold,
      input  red, yellow, green, state_o, phase_done
   );

   modport slave (
      input  tick_in, hold,
      output red, yellow, green, state_o, phase_done
   );
`endif
endinterface

// File: rtl/traffic_light_fsm.sv
// Traffic-light controller: RED -> RED_YELLOW -> GREEN -> YELLOW, dwell counted in divider ticks.
// Latency: lamps/state_o/phase_done are registered and update on the clk edge that samples the final tick.
// Backpressure: none; hold=1 discards ticks (lost, not deferred) and freezes the sequence.
//
// Ports: clk (system clock), rst (async active-high reset), tl (traffic_light_fsm_if.slave):
//   tick_in  - divider square wave, synchronous to clk, rising edge = one tick
//   hold     - while 1, detected ticks are ignored
//   red/yellow/green - lamp outputs
//   state_o  - 0=RED, 1=RED_YELLOW, 2=GREEN, 3=YELLOW
//   phase_done - one-clk pulse on each state transition
//   ped_req/ped_walk - pedestrian request/walk, present only with TLC_PED_REQ_EN defined
// Optional feature macro: TLC_PED_REQ_EN (pedestrian request shortens GREEN to MIN_GREEN_TICKS).
module traffic_light_fsm #(
   parameter int RED_TICKS        = 8,
   parameter int RED_YELLOW_TICKS = 2,
   parameter int GREEN_TICKS      = 6,
   parameter int YELLOW_TICKS     = 3,
   parameter int MIN_GREEN_TICKS  = 2,
   parameter int CNT_W            = 8
) (
   input logic               clk,
   input logic               rst,
   traffic_light_fsm_if.slave tl
);

   // Every dwell value must fit the counter.
   if (RED_TICKS        >= (1 << CNT_W) ||
       RED_YELLOW_TICKS >= (1 << CNT_W) ||
       GREEN_TICKS      >= (1 << CNT_W) ||
       YELLOW_TICKS     >= (1 << CNT_W) ||
       MIN_GREEN_TICKS  >= (1 << CNT_W)) begin : g_bad_param
      $error("traffic_light_fsm: a *_TICKS parameter does not fit in CNT_W bits");
   end

   // A zero dwell would never match "count == dur-1", so clamp to one tick.
   localparam int RED_D        = (RED_TICKS        < 1) ? 1 : RED_TICKS;
   localparam int RED_YELLOW_D = (RED_YELLOW_TICKS < 1) ? 1 : RED_YELLOW_TICKS;
   localparam int GREEN_D      = (GREEN_TICKS      < 1) ? 1 : GREEN_TICKS;
   localparam int YELLOW_D     = (YELLOW_TICKS     < 1) ? 1 : YELLOW_TICKS;

   localparam logic [CNT_W-1:0] RED_LAST        = CNT_W'(RED_D - 1);
   localparam logic [CNT_W-1:0] RED_YELLOW_LAST = CNT_W'(RED_YELLOW_D - 1);
   localparam logic [CNT_W-1:0] GREEN_LAST      = CNT_W'(GREEN_D - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST     = CNT_W'(YELLOW_D - 1);

`ifdef TLC_PED_REQ_EN
   localparam int               MIN_GREEN_D    = (MIN_GREEN_TICKS < 1) ? 1 : MIN_GREEN_TICKS;
   localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_GREEN_D - 1);
`endif

   typedef enum logic [1:0] {
      S_RED        = 2'd0,
      S_RED_YELLOW = 2'd1,
      S_GREEN      = 2'd2,
      S_YELLOW     = 2'd3
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] dwell_cnt;
   logic [CNT_W-1:0] last_cnt;
   logic             tick_q;
   logic             tick;
   logic             phase_end;
   logic [2:0]       lamp_q;      // {red, yellow, green}
   logic             phase_done_q;

`ifdef TLC_PED_REQ_EN
   logic             ped_pending;
   logic             ped_walk_q;
`endif

   // Lamp pattern for a state, as {red, yellow, green}.
   function automatic logic [2:0] lamps_of(input state_t s);
      case (s)
         S_RED:        lamps_of = 3'b100;
         S_RED_YELLOW: lamps_of = 3'b110;
         S_GREEN:      lamps_of = 3'b001;
         S_YELLOW:     lamps_of = 3'b010;
         default:      lamps_of = 3'b100;
      endcase
   endfunction

   // tick_q resets to 1 so a tick_in already high at reset release is not a rising edge.
   assign tick = tl.tick_in & ~tick_q & ~tl.hold;

   always_comb begin
      last_cnt   = RED_LAST;
      next_state = S_RED;
      case (state)
         S_RED: begin
            last_cnt   = RED_LAST;
            next_state = S_RED_YELLOW;
         end
         S_RED_YELLOW: begin
            last_cnt   = RED_YELLOW_LAST;
            next_state = S_GREEN;
         end
         S_GREEN: begin
            last_cnt   = GREEN_LAST;
            next_state = S_YELLOW;
         end
         S_YELLOW: begin
            last_cnt   = YELLOW_LAST;
            next_state = S_RED;
         end
         default: begin
            last_cnt   = RED_LAST;
            next_state = S_RED;
         end
      endcase
   end

   always_comb begin
      phase_end = (dwell_cnt == last_cnt);
`ifdef TLC_PED_REQ_EN
      // A waiting pedestrian cuts GREEN short once the minimum green has been served.
      if (state == S_GREEN && ped_pending && dwell_cnt >= MIN_GREEN_LAST) begin
         phase_end = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_RED;
         dwell_cnt    <= '0;
         tick_q       <= 1'b1;
         lamp_q       <= 3'b100;
         phase_done_q <= 1'b0;
`ifdef TLC_PED_REQ_EN
         ped_pending  <= 1'b0;
         ped_walk_q   <= 1'b0;
`endif
      end else begin
         tick_q       <= tl.tick_in;
         phase_done_q <= 1'b0;
         if (tick) begin
            if (phase_end) begin
               state        <= next_state;
               dwell_cnt    <= '0;
               phase_done_q <= 1'b1;
               lamp_q       <= lamps_of(next_state);
`ifdef TLC_PED_REQ_EN
               if (state == S_YELLOW && ped_pending) begin
                  ped_walk_q  <= 1'b1;
                  ped_pending <= 1'b0;
               end
               if (state == S_RED) begin
                  ped_walk_q <= 1'b0;
               end
`endif
            end else begin
               dwell_cnt <= dwell_cnt + 1'b1;
            end
         end
`ifdef TLC_PED_REQ_EN
         // Placed last so a request in the same clk as the hand-off is kept for the next GREEN.
         if (tl.ped_req) begin
            ped_pending <= 1'b1;
         end
`endif
      end
   end

   assign tl.red        = lamp_q[2];
   assign tl.yellow     = lamp_q[1];
   assign tl.green      = lamp_q[0];
   assign tl.state_o    = state;
   assign tl.phase_done = phase_done_q;
`ifdef TLC_PED_REQ_EN
   assign tl.ped_walk   = ped_walk_q;
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: directed tick sequences with a queue of expected transitions
// checked by a monitor on every phase_done pulse, plus per-cycle lamp invariant checks.
// Ports exercised through traffic_light_fsm_if; pedestrian section built only with TLC_PED_REQ_EN.
module tb_traffic_light_fsm;

   logic clk;
   logic rst;

   traffic_light_fsm_if tl ();

   traffic_light_fsm dut (
      .clk (clk),
      .rst (rst),
      .tl  (tl.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int st;
      int walk;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp    = 0;
   int n_err    = 0;
   int n_pd     = 0;
   int tick_id  = 0;
   int prev_pd  = 0;

   // Reference sequence model (tick-level)
   int m_state = 0;
   int m_dwell = 0;
   int m_pend  = 0;
   int m_walk  = 0;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   function automatic int dur(input int s);
      case (s)
         0: dur = 8;
         1: dur = 2;
         2: dur = 6;
         default: dur = 3;
      endcase
   endfunction

   // Required {red,yellow,green} for a state_o value.
   function automatic int lamp_exp(input int s);
      case (s)
         0: lamp_exp = 4;
         1: lamp_exp = 6;
         2: lamp_exp = 1;
         default: lamp_exp = 2;
      endcase
   endfunction

   // One accepted tick: advance the model and queue the transition it predicts.
   task automatic model_tick();
      bit   last;
      exp_t e;
      tick_id++;
      last = (m_dwell == dur(m_state) - 1);
`ifdef TLC_PED_REQ_EN
      if (m_state == 2 && m_pend != 0 && m_dwell >= 1) last = 1'b1;
`endif
      if (last) begin
`ifdef TLC_PED_REQ_EN
         if (m_state == 3 && m_pend != 0) begin
            m_walk = 1;
            m_pend = 0;
         end
         if (m_state == 0) m_walk = 0;
`endif
         m_state = (m_state + 1) % 4;
         m_dwell = 0;
         e.id   = tick_id;
         e.st   = m_state;
         e.walk = m_walk;
         exp_q.push_back(e);
      end else begin
         m_dwell++;
      end
   endtask

   // One tick_in period of 22 clk (rising edge, 11 high, 11 low), hold applied at the edge.
   task automatic do_tick(input logic h);
      @(posedge clk); #1;
      tl.hold    = h;
      tl.tick_in = 1'b1;
      if (!h) model_tick();
      repeat (11) @(posedge clk);
      #1;
      tl.tick_in = 1'b0;
      tl.hold    = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic model_reset();
      m_state = 0;
      m_dwell = 0;
      m_pend  = 0;
      m_walk  = 0;
   endtask

   // Monitor: invariants every cycle, scoreboard pop on each phase_done.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("lamp_red_green_excl", int'(tl.red & tl.green), 0);
         chk("lamp_decode", int'({tl.red, tl.yellow, tl.green}), lamp_exp(int'(tl.state_o)));
         if (tl.phase_done) begin
            n_pd++;
            chk("phase_done_width", prev_pd, 0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_phase_done: state_o=%0d with no transition due (t=%0t)",
                        tl.state_o, $time);
            end else begin
               e = exp_q.pop_front();
               chk("transition_tick", tick_id, e.id);
               chk("transition_state", int'(tl.state_o), e.st);
`ifdef TLC_PED_REQ_EN
               chk("transition_walk", int'(tl.ped_walk), e.walk);
`endif
            end
         end
         prev_pd = int'(tl.phase_done);
      end else begin
         prev_pd = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d transitions pending, expected 0",
               exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int pd_base;
      logic prev_t;
      int rises;
      logic t, h;

      rst        = 1'b1;
      tl.tick_in = 1'b1;
      tl.hold    = 1'b0;
`ifdef TLC_PED_REQ_EN
      tl.ped_req = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("reset_red", int'(tl.red), 1);
      chk("reset_yellow", int'(tl.yellow), 0);
      chk("reset_green", int'(tl.green), 0);
      chk("reset_state", int'(tl.state_o), 0);
      chk("reset_phase_done", int'(tl.phase_done), 0);
      rst = 1'b0;
      // tick_in is high at release: first edge must not be taken as a tick
      @(posedge clk); #1;
      chk("no_spurious_tick_state", int'(tl.state_o), 0);
      chk("no_spurious_tick_pd", int'(tl.phase_done), 0);
      chk("no_spurious_tick_dwell", int'(dut.dwell_cnt), 0);
      tl.tick_in = 1'b0;
      repeat (10) @(posedge clk);

      // Full 19-tick cycle
      pd_base = n_pd;
      for (int i = 0; i < 19; i++) begin
         do_tick(1'b0);
         if (i == 6) chk("still_red_after_7", int'(tl.state_o), 0);
      end
      chk("cycle_phase_done_count", n_pd - pd_base, 4);
      chk("cycle_back_to_red", int'(tl.state_o), 0);

      // Hold in GREEN after 2 ticks
      for (int i = 0; i < 12; i++) do_tick(1'b0);
      chk("green_before_hold", int'(tl.state_o), 2);
      for (int i = 0; i < 5; i++) do_tick(1'b1);
      chk("hold_state", int'(tl.state_o), 2);
      chk("hold_dwell", int'(dut.dwell_cnt), 2);
      for (int i = 0; i < 3; i++) do_tick(1'b0);
      chk("green_after_3_more", int'(tl.state_o), 2);
      do_tick(1'b0);
      chk("yellow_after_4_more", int'(tl.state_o), 3);

      // Asynchronous reset in YELLOW at dwell 1
      do_tick(1'b0);
      chk("yellow_dwell_before_rst", int'(dut.dwell_cnt), 1);
      @(posedge clk); #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_red", int'(tl.red), 1);
      chk("async_rst_yellow", int'(tl.yellow), 0);
      chk("async_rst_state", int'(tl.state_o), 0);
      chk("async_rst_dwell", int'(dut.dwell_cnt), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 7; i++) do_tick(1'b0);
      chk("red_after_rst_7", int'(tl.state_o), 0);
      do_tick(1'b0);
      chk("red_yellow_after_rst_8", int'(tl.state_o), 1);

      // Random tick/hold levels until 2000 rising edges
      prev_t = tl.tick_in;
      rises  = 0;
      while (rises < 2000) begin
         @(posedge clk); #1;
         t = 1'($urandom_range(0, 1));
         h = ($urandom_range(0, 3) == 0);
         tl.tick_in = t;
         tl.hold    = h;
         if (t && !prev_t) begin
            rises++;
            if (!h) model_tick();
         end
         prev_t = t;
      end
      @(posedge clk); #1;
      tl.tick_in = 1'b0;
      tl.hold    = 1'b0;
      repeat (5) @(posedge clk);
      chk("random_state_match", int'(tl.state_o), m_state);

`ifdef TLC_PED_REQ_EN
      // Pedestrian request during RED
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tl.ped_req = 1'b1;
      m_pend     = 1;
      @(posedge clk); #1;
      tl.ped_req = 1'b0;
      for (int i = 0; i < 10; i++) do_tick(1'b0);
      chk("ped_green_entered", int'(tl.state_o), 2);
      do_tick(1'b0);
      chk("ped_green_one_tick", int'(tl.state_o), 2);
      do_tick(1'b0);
      chk("ped_green_cut_short", int'(tl.state_o), 3);
      for (int i = 0; i < 3; i++) do_tick(1'b0);
      chk("ped_red_reached", int'(tl.state_o), 0);
      chk("ped_walk_on", int'(tl.ped_walk), 1);
      for (int i = 0; i < 7; i++) do_tick(1'b0);
      chk("ped_walk_held_in_red", int'(tl.ped_walk), 1);
      do_tick(1'b0);
      chk("ped_walk_off_red_yellow", int'(tl.ped_walk), 0);
      chk("ped_state_red_yellow", int'(tl.state_o), 1);
`endif

      repeat (30) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
